// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl shared types and constants.
// States, digit widths and preset saturation helper.
package timer_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam int KEY_W   = 4;
   localparam int UNITS_W = 4;
   localparam int TENS_W  = 3;
   localparam int MIN_W   = 4;

   localparam logic [KEY_W-1:0] MAX_TENS  = 4'd5;
   localparam logic [KEY_W-1:0] MAX_DIGIT = 4'd9;

   // Raw keypad fields; tens is narrowed only when driven out.
   typedef struct packed {
      logic [MIN_W-1:0]   min;
      logic [KEY_W-1:0]   tens;
      logic [UNITS_W-1:0] units;
   } preset_t;

   function automatic logic [TENS_W-1:0] sat_tens(
      input logic [KEY_W-1:0] t
   );
      logic [KEY_W-1:0] v;
      v = (t > MAX_TENS) ? MAX_TENS : t;
      return v[TENS_W-1:0];
   endfunction

endpackage

// File: rtl/timer_ctrl_tick_prescaler.sv
// Count-tick prescaler for timer_ctrl.
// Wraps every TICK_DIV enabled cycles; restart zeroes it.
module tick_prescaler #(
   parameter int TICK_DIV = 100
) (
   input  logic clk,
   input  logic clearn,
   input  logic restart,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Run controller for the min:sec countdown timer.
// Holds the keypad preset, drives load/enable/clear of the digit chain.
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 100
) (
   input  logic               clk,
   input  logic               clearn,
   input  logic               start,
   input  logic               stop,
   input  logic               clr,
   input  logic               key_valid,
   input  logic [KEY_W-1:0]   key_data,
   input  logic               units_zero,
   input  logic               tens_zero,
   input  logic               min_zero,
   output logic [UNITS_W-1:0] units_data,
   output logic [TENS_W-1:0]  tens_data,
   output logic [MIN_W-1:0]   min_data,
   output logic               cnt_loadn,
   output logic               cnt_en,
   output logic               cnt_clearn,
   output logic               running,
   output logic               paused,
   output logic               done
);

   state_t  state, state_nx;
   preset_t pre, pre_nx;
   logic    clr_q, clr_nx;
   logic    all_zero;
   logic    preset_zero;
   logic    key_ok;
   logic    tick;
   logic    presc_run;
   logic    presc_restart;

   assign all_zero    = units_zero & tens_zero & min_zero;
   assign preset_zero = (pre == '0);
   assign key_ok      = key_valid && (key_data <= MAX_DIGIT);

   assign presc_restart = (state == ST_LOAD);
   assign presc_run     = (state == ST_RUN) && !stop && !clr;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk     (clk),
      .clearn  (clearn),
      .restart (presc_restart),
      .run     (presc_run),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state <= ST_IDLE;
         pre   <= '0;
         clr_q <= 1'b0;
      end else begin
         state <= state_nx;
         pre   <= pre_nx;
         clr_q <= clr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pre_nx   = pre;
      clr_nx   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (clr) begin
               pre_nx = '0;
               clr_nx = 1'b1;
            end else if (stop) begin
               state_nx = ST_IDLE;
            end else if (start) begin
               if (!preset_zero) state_nx = ST_LOAD;
            end else if (key_ok) begin
               pre_nx = '{min:   pre.tens,
                          tens:  pre.units,
                          units: key_data};
            end
         end
         ST_LOAD: begin
            state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (clr) begin
               state_nx = ST_IDLE;
               pre_nx   = '0;
               clr_nx   = 1'b1;
            end else if (stop) begin
               state_nx = ST_PAUSE;
            end else if (all_zero) begin
               state_nx = ST_DONE;
            end
         end
         ST_PAUSE: begin
            if (clr) begin
               state_nx = ST_IDLE;
               pre_nx   = '0;
               clr_nx   = 1'b1;
            end else if (start && !stop) begin
               state_nx = ST_RUN;
            end
         end
         ST_DONE: begin
            if (clr) begin
               state_nx = ST_IDLE;
               pre_nx   = '0;
               clr_nx   = 1'b1;
            end else if (stop || start) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   assign units_data = pre.units;
   assign tens_data  = sat_tens(pre.tens);
   assign min_data   = pre.min;

   assign cnt_loadn  = (state != ST_LOAD);
   assign cnt_clearn = ~clr_q;
   // Suppressed on the cycle a request or terminal zero is seen.
   assign cnt_en     = (state == ST_RUN) & tick & ~all_zero
                     & ~stop & ~clr;

   assign running = (state == ST_LOAD) || (state == ST_RUN);
   assign paused  = (state == ST_PAUSE);
   assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized bench for timer_ctrl against a seconds-level model.
// Also models the counter chain that feeds back the zero flags.
module tb_timer_ctrl;

   localparam int TD = 4;
   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_PAUSE = 3;
   localparam int M_DONE  = 4;

   logic       clk = 1'b0;
   logic       clearn = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clr = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_data = 4'd0;
   logic       units_zero = 1'b1;
   logic       tens_zero = 1'b1;
   logic       min_zero = 1'b1;
   logic [3:0] units_data;
   logic [2:0] tens_data;
   logic [3:0] min_data;
   logic       cnt_loadn, cnt_en, cnt_clearn;
   logic       running, paused, done;

   timer_ctrl #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .clearn     (clearn),
      .start      (start),
      .stop       (stop),
      .clr        (clr),
      .key_valid  (key_valid),
      .key_data   (key_data),
      .units_zero (units_zero),
      .tens_zero  (tens_zero),
      .min_zero   (min_zero),
      .units_data (units_data),
      .tens_data  (tens_data),
      .min_data   (min_data),
      .cnt_loadn  (cnt_loadn),
      .cnt_en     (cnt_en),
      .cnt_clearn (cnt_clearn),
      .running    (running),
      .paused     (paused),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model: mode, preset digits, prescaler phase, pending clear
   int m_st, m_min, m_tens, m_units, m_presc, secs;
   bit m_clr;
   bit e_loadn, e_clearn, e_en;

   // stats and snapshots
   int cyc = 0;
   int n_load, n_en, first_en, last_en, en_gap, done_cyc;
   int s_min, s_tens, s_units;
   bit s_running, s_paused, s_done, s_clearn;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d",
                  tag, cyc, got, exp);
      end
   endtask

   function automatic int load_secs();
      int t;
      t = (m_tens > 5) ? 5 : m_tens;
      return m_min * 60 + t * 10 + m_units;
   endfunction

   task automatic drive_flags();
      units_zero = (secs % 10 == 0);
      tens_zero  = ((secs / 10) % 6 == 0);
      min_zero   = (secs < 60);
   endtask

   task automatic compare_all(input string tag);
      int t;
      t = (m_tens > 5) ? 5 : m_tens;
      e_loadn  = (m_st != M_LOAD);
      e_clearn = !m_clr;
      e_en     = (m_st == M_RUN) && (m_presc == TD - 1) &&
                 (secs != 0) && !stop && !clr;
      check({tag, ".loadn"}, 32'(cnt_loadn), 32'(e_loadn));
      check({tag, ".clearn"}, 32'(cnt_clearn), 32'(e_clearn));
      check({tag, ".en"}, 32'(cnt_en), 32'(e_en));
      check({tag, ".running"}, 32'(running),
            32'(m_st == M_LOAD || m_st == M_RUN));
      check({tag, ".paused"}, 32'(paused), 32'(m_st == M_PAUSE));
      check({tag, ".done"}, 32'(done), 32'(m_st == M_DONE));
      check({tag, ".min"}, 32'(min_data), m_min);
      check({tag, ".tens"}, 32'(tens_data), t);
      check({tag, ".units"}, 32'(units_data), m_units);
      s_min = int'(min_data);
      s_tens = int'(tens_data);
      s_units = int'(units_data);
      s_running = running;
      s_paused = paused;
      s_done = done;
      s_clearn = cnt_clearn;
   endtask

   task automatic wipe_preset();
      m_min = 0;
      m_tens = 0;
      m_units = 0;
      m_clr = 1'b1;
   endtask

   task automatic clear_stats();
      n_load = 0;
      n_en = 0;
      first_en = -1;
      last_en = -1;
      en_gap = -1;
      done_cyc = -1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clearn = 1'b0;
      {start, stop, clr, key_valid} = 4'b0;
      key_data = 4'd0;
      #1;
      m_st = M_IDLE;
      m_min = 0;
      m_tens = 0;
      m_units = 0;
      m_presc = 0;
      m_clr = 1'b0;
      secs = 0;
      drive_flags();
      #1;
      compare_all("reset");
      #1;
      clearn = 1'b1;
   endtask

   task automatic step(input bit s, input bit p, input bit c,
                       input bit kv, input int kd);
      bit az;
      @(negedge clk);
      start = s;
      stop = p;
      clr = c;
      key_valid = kv;
      key_data = 4'(kd);
      drive_flags();
      az = (secs == 0);
      #1;
      compare_all("cyc");
      if (!cnt_loadn) n_load++;
      if (cnt_en) begin
         n_en++;
         if (first_en < 0) first_en = cyc;
         if (last_en >= 0) en_gap = cyc - last_en;
         last_en = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      @(posedge clk);
      // counter chain
      if (!e_clearn) secs = 0;
      else if (!e_loadn) secs = load_secs();
      else if (e_en && secs > 0) secs--;
      // controller rules
      m_clr = 1'b0;
      case (m_st)
         M_IDLE: begin
            if (c) wipe_preset();
            else if (p) m_st = M_IDLE;
            else if (s) begin
               if (m_min + m_tens + m_units != 0) m_st = M_LOAD;
            end else if (kv && kd <= 9) begin
               m_min = m_tens;
               m_tens = m_units;
               m_units = kd;
            end
         end
         M_LOAD: begin
            m_presc = 0;
            m_st = M_RUN;
         end
         M_RUN: begin
            if (c) begin
               wipe_preset();
               m_st = M_IDLE;
            end else if (p) begin
               m_st = M_PAUSE;
            end else begin
               m_presc = (m_presc + 1) % TD;
               if (az) m_st = M_DONE;
            end
         end
         M_PAUSE: begin
            if (c) begin
               wipe_preset();
               m_st = M_IDLE;
            end else if (s && !p) begin
               m_st = M_RUN;
            end
         end
         default: begin
            if (c) begin
               wipe_preset();
               m_st = M_IDLE;
            end else if (s || p) begin
               m_st = M_IDLE;
            end
         end
      endcase
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic key(input int k);
      step(0, 0, 0, 1, k);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit hit, expected finish");
      $fatal(1);
   end

   initial begin
      int t0;
      clear_stats();
      do_reset();

      key(1); key(3); key(5); idle(1);
      check("keys135.min", s_min, 1);
      check("keys135.tens", s_tens, 3);
      check("keys135.units", s_units, 5);
      key(12); idle(1);
      check("key12.units", s_units, 5);
      key(0); key(9); key(9); idle(1);
      check("sat.tens", s_tens, 5);
      check("sat.units", s_units, 9);

      step(0, 0, 1, 0, 0); key(2); idle(1);
      clear_stats();
      t0 = cyc;
      step(1, 0, 0, 0, 0);
      idle(14);
      check("run2.loads", n_load, 1);
      check("run2.pulses", n_en, 2);
      check("run2.gap", en_gap, TD);
      check("run2.donelat", done_cyc - t0, 11);

      step(1, 0, 0, 0, 0); idle(1);
      check("rerun.idle", 32'(s_running | s_done), 0);
      check("rerun.kept", s_units, 2);
      clear_stats();
      t0 = cyc;
      step(1, 0, 0, 0, 0);
      idle(14);
      check("rerun.pulses", n_en, 2);
      check("rerun.donelat", done_cyc - t0, 11);
      step(0, 1, 0, 0, 0);

      step(0, 0, 1, 0, 0); key(1); key(0); idle(1);
      t0 = cyc;
      step(1, 0, 0, 0, 0);
      idle(7);
      clear_stats();
      step(0, 1, 0, 0, 0);
      idle(1);
      check("pause.noen", n_en, 0);
      check("pause.flag", 32'(s_paused), 1);
      idle(9);
      clear_stats();
      t0 = cyc;
      step(1, 0, 0, 0, 0);
      idle(4);
      check("resume.lat", first_en - t0, 2);

      step(0, 0, 1, 0, 0); key(5);
      step(1, 0, 0, 0, 0); idle(3);
      step(0, 1, 1, 0, 0);
      idle(1);
      check("stopclr.clearn", 32'(s_clearn), 0);
      check("stopclr.running", 32'(s_running), 0);
      check("stopclr.preset", s_units, 0);
      idle(1);
      check("stopclr.release", 32'(s_clearn), 1);

      clear_stats();
      step(1, 0, 0, 0, 0); idle(3);
      check("zero.loads", n_load, 0);
      check("zero.running", 32'(s_running), 0);

      key(3); step(1, 0, 0, 0, 0); idle(6);
      do_reset();
      check("midreset.running", 32'(s_running), 0);

      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 2999) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 30,
                 int'($urandom_range(0, 15)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
